wb_register_file: RTL and testbench

WB_REGISTER_FILE -- requirements
Module: wb_register_file

---
 rtl/wb_register_file.sv | 90 +++++++++
 tb/tb_wb_register_file.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// Register file with write-through bypass, a load-pending scoreboard and a count of committed writes.
// Register 0 is hard-wired to zero and is never written, bypassed or marked pending.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] RegAddr_i,
    input  logic [DATA_W-1:0] RegData_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    input  logic              PendSet_i,
    input  logic [ADDR_W-1:0] PendAddr_i,
    output logic              RS1busy_o,
    output logic              RS2busy_o,
    output logic [31:0]       WrCount_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;
    logic [31:0]       wr_count_q;
    logic [31:0]       wr_count_d;
    logic              commit;
    logic              byp1;
    logic              byp2;

    assign commit = RegWrite_i && (RegAddr_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[RegAddr_i] <= RegData_i;
        end
    end

    // Clear first so that a same-address set overrides it: the newer load is still outstanding.
    always_comb begin
        pend_d = pend_q;
        if (commit) begin
            pend_d[RegAddr_i] = 1'b0;
        end
        if (PendSet_i && (PendAddr_i != '0)) begin
            pend_d[PendAddr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    assign wr_count_d = commit ? wr_count_q + 32'd1 : wr_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q     <= '0;
            wr_count_q <= '0;
        end else begin
            pend_q     <= pend_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign byp1 = RegWrite_i && (RegAddr_i == RS1addr_i);
    assign byp2 = RegWrite_i && (RegAddr_i == RS2addr_i);

    // Storage is already zero during reset, so only the bypass can show non-zero data then.
    always_comb begin
        RS1data_o = '0;
        RS2data_o = '0;
        if (RS1addr_i != '0) begin
            RS1data_o = byp1 ? RegData_i : regs_q[RS1addr_i];
        end
        if (RS2addr_i != '0) begin
            RS2data_o = byp2 ? RegData_i : regs_q[RS2addr_i];
        end
    end

    assign RS1busy_o = !rst_i && (RS1addr_i != '0) && pend_q[RS1addr_i] && !byp1;
    assign RS2busy_o = !rst_i && (RS2addr_i != '0) && pend_q[RS2addr_i] && !byp2;

    assign WrCount_o = wr_count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: reads, x0 protection, bypass, scoreboard, counter wrap, async reset.
module tb_wb_register_file;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic [4:0]  RegAddr_i;
    logic [31:0] RegData_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [31:0] RS1data_o;
    logic [31:0] RS2data_o;
    logic        PendSet_i;
    logic [4:0]  PendAddr_i;
    logic        RS1busy_o;
    logic        RS2busy_o;
    logic [31:0] WrCount_o;

    int n_checks = 0;
    int n_errors = 0;

    wb_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .RegWrite_i (RegWrite_i),
        .RegAddr_i  (RegAddr_i),
        .RegData_i  (RegData_i),
        .RS1addr_i  (RS1addr_i),
        .RS2addr_i  (RS2addr_i),
        .RS1data_o  (RS1data_o),
        .RS2data_o  (RS2data_o),
        .PendSet_i  (PendSet_i),
        .PendAddr_i (PendAddr_i),
        .RS1busy_o  (RS1busy_o),
        .RS2busy_o  (RS2busy_o),
        .WrCount_o  (WrCount_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RegWrite_i = 1'b0;
        RegAddr_i  = '0;
        RegData_i  = '0;
        PendSet_i  = 1'b0;
        PendAddr_i = '0;
    endtask

    // Advance through one rising edge and settle at the following falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite_i = 1'b1;
        RegAddr_i  = a;
        RegData_i  = d;
    endtask

    initial begin
        idle();
        RS1addr_i = '0;
        RS2addr_i = '0;
        rst_i = 1'b1;
        @(negedge clk_i);
        RS1addr_i = 5'd3;
        #1;
        check("rst_count", WrCount_o, 32'd0);
        check("rst_rs1data", RS1data_o, 32'd0);
        check("rst_busy", {31'd0, RS1busy_o}, 32'd0);
        rst_i = 1'b0;
        step();

        // write then read
        wr(5'd5, 32'hDEADBEEF);
        step();
        idle();
        RS1addr_i = 5'd5;
        #1;
        check("wr_read", RS1data_o, 32'hDEADBEEF);
        check("wr_count1", WrCount_o, 32'd1);

        // x0 protection, including no bypass on address 0
        wr(5'd0, 32'h12345678);
        RS1addr_i = 5'd0;
        #1;
        check("x0_bypass", RS1data_o, 32'd0);
        step();
        idle();
        #1;
        check("x0_read", RS1data_o, 32'd0);
        check("x0_count", WrCount_o, 32'd1);

        // bypass over a stored value
        wr(5'd7, 32'h1);
        step();
        wr(5'd7, 32'hA5A5A5A5);
        RS2addr_i = 5'd7;
        #1;
        check("byp_same_cycle", RS2data_o, 32'hA5A5A5A5);
        step();
        idle();
        #1;
        check("byp_stored", RS2data_o, 32'hA5A5A5A5);
        check("byp_count", WrCount_o, 32'd3);

        // scoreboard set, clear by write-back
        PendSet_i  = 1'b1;
        PendAddr_i = 5'd9;
        RS1addr_i  = 5'd9;
        RS2addr_i  = 5'd5;
        step();
        idle();
        #1;
        check("sb_set", {31'd0, RS1busy_o}, 32'd1);
        check("sb_other", {31'd0, RS2busy_o}, 32'd0);
        wr(5'd9, 32'h99);
        #1;
        check("sb_wb_cycle", {31'd0, RS1busy_o}, 32'd0);
        check("sb_wb_data", RS1data_o, 32'h99);
        step();
        idle();
        #1;
        check("sb_cleared", {31'd0, RS1busy_o}, 32'd0);
        check("sb_count", WrCount_o, 32'd4);

        // set and clear to the same address: set wins
        wr(5'd9, 32'h9A);
        PendSet_i  = 1'b1;
        PendAddr_i = 5'd9;
        step();
        idle();
        #1;
        check("sb_set_wins", {31'd0, RS1busy_o}, 32'd1);

        // set and clear to different addresses both apply
        wr(5'd9, 32'h9B);
        PendSet_i  = 1'b1;
        PendAddr_i = 5'd10;
        RS2addr_i  = 5'd10;
        step();
        idle();
        #1;
        check("sb_diff_clr", {31'd0, RS1busy_o}, 32'd0);
        check("sb_diff_set", {31'd0, RS2busy_o}, 32'd1);
        check("sb_diff_count", WrCount_o, 32'd6);

        // re-setting a set bit and writing a clean register are harmless
        PendSet_i  = 1'b1;
        PendAddr_i = 5'd10;
        step();
        idle();
        #1;
        check("sb_reset_bit", {31'd0, RS2busy_o}, 32'd1);
        PendSet_i  = 1'b1;
        PendAddr_i = 5'd0;
        RS1addr_i  = 5'd0;
        step();
        idle();
        #1;
        check("sb_x0_busy", {31'd0, RS1busy_o}, 32'd0);

        // counter wrap via backdoor preload
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_q;
        #1;
        check("wrap_preload", WrCount_o, 32'hFFFFFFFF);
        wr(5'd3, 32'h33);
        step();
        idle();
        #1;
        check("wrap_zero", WrCount_o, 32'd0);

        // async reset between edges
        RS1addr_i = 5'd5;
        RS2addr_i = 5'd10;
        #1;
        check("pre_rst_data", RS1data_o, 32'hDEADBEEF);
        rst_i = 1'b1;
        #1;
        check("arst_rs1data", RS1data_o, 32'd0);
        check("arst_rs2data", RS2data_o, 32'd0);
        check("arst_busy", {31'd0, RS2busy_o}, 32'd0);
        check("arst_count", WrCount_o, 32'd0);
        wr(5'd5, 32'h77);
        PendSet_i  = 1'b1;
        PendAddr_i = 5'd5;
        #1;
        check("arst_bypass", RS1data_o, 32'h77);
        step();
        idle();
        rst_i = 1'b0;
        #1;
        check("rst_wr_ignored", RS1data_o, 32'd0);
        check("rst_pend_ignored", {31'd0, RS1busy_o}, 32'd0);
        check("rst_count_held", WrCount_o, 32'd0);

        // resume after reset
        wr(5'd5, 32'h55);
        step();
        idle();
        #1;
        check("resume_data", RS1data_o, 32'h55);
        check("resume_count", WrCount_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
